// File: rtl/hls_run_pkg.sv
// Shared types for the HLS run controller: FSM states, result status codes
// and the width of one result record.
package hls_run_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRST,
        S_START,
        S_WAIT,
        S_RECORD,
        S_BATCH_END
    } run_state_e;

    typedef enum logic [1:0] {
        ST_NOCMP   = 2'b00,
        ST_PASS    = 2'b01,
        ST_FAIL    = 2'b10,
        ST_TIMEOUT = 2'b11
    } run_status_e;

    localparam int STATUS_W = 2;

    // Record layout is {status, cycles, run_idx}, status in the MSBs.
    function automatic int rec_width(input int cycle_w, input int run_w);
        return STATUS_W + cycle_w + run_w;
    endfunction

endpackage

// File: rtl/hls_result_fifo.sv
// Result FIFO; a push into a full FIFO is accepted when a pop happens in
// the same cycle.
module hls_result_fifo #(
    parameter int WIDTH = 42,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             push_accept,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             full, do_pop;

    // Extra pointer bit tells full from empty when the indices match.
    assign empty       = (wr_ptr == rd_ptr);
    assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop      = pop && !empty;
    assign push_accept = push && (!full || do_pop);
    assign pop_data    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_accept) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)      rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (push_accept) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/hls_run_controller.sv
// Batch run controller for an HLS accelerator: resets, starts and times each
// run, then queues {status, cycles, run index} results for a consumer.
module hls_run_controller
    import hls_run_pkg::*;
#(
    parameter int CYCLE_W    = 32,
    parameter int RUN_W      = 8,
    parameter int TIMEOUT    = 200000000,
    parameter int RST_CYCLES = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               cmd_start,
    input  logic [RUN_W-1:0]   cmd_runs,
    input  logic               cmd_compare,
    output logic               dut_reset,
    output logic               dut_start_port,
    input  logic               dut_done_port,
    input  logic               dut_success,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [1:0]         res_status,
    output logic [CYCLE_W-1:0] res_cycles,
    output logic [RUN_W-1:0]   res_run_idx,
    output logic               busy,
    output logic               batch_done
);

    localparam int REC_W = rec_width(CYCLE_W, RUN_W);
    localparam int RC_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    run_state_e         state_q, state_d;
    logic [CYCLE_W-1:0] counter_q, rec_cycles_q;
    logic [RUN_W-1:0]   run_idx_q, runs_q;
    logic [RC_W-1:0]    rst_cnt_q;
    run_status_e        rec_status_q;
    logic               cmp_q;

    logic               timed_out, last_run, push, push_accept, fifo_empty;
    logic [REC_W-1:0]   push_data, head;

    assign timed_out = (counter_q == CYCLE_W'(TIMEOUT));
    assign last_run  = (run_idx_q == runs_q - RUN_W'(1));
    assign push_data = {rec_status_q, rec_cycles_q, run_idx_q};

    // Gated with reset so the accelerator is held in reset with us.
    assign dut_reset = reset && (state_q != S_DRST);
    assign busy      = (state_q != S_IDLE);

    always_comb begin
        state_d        = state_q;
        push           = 1'b0;
        dut_start_port = 1'b0;
        batch_done     = 1'b0;
        case (state_q)
            S_IDLE:      if (cmd_start) state_d = (cmd_runs == '0) ? S_BATCH_END : S_DRST;
            S_DRST:      if (rst_cnt_q == RC_W'(RST_CYCLES - 1)) state_d = S_START;
            S_START: begin
                dut_start_port = 1'b1;
                state_d        = S_WAIT;
            end
            S_WAIT:      if (dut_done_port || timed_out) state_d = S_RECORD;
            S_RECORD: begin
                push = 1'b1;
                if (push_accept) state_d = last_run ? S_BATCH_END : S_DRST;
            end
            S_BATCH_END: begin
                batch_done = 1'b1;
                state_d    = S_IDLE;
            end
            default:     state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            counter_q    <= '0;
            rec_cycles_q <= '0;
            run_idx_q    <= '0;
            runs_q       <= '0;
            rst_cnt_q    <= '0;
            rec_status_q <= ST_NOCMP;
            cmp_q        <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: if (cmd_start) begin
                    runs_q    <= cmd_runs;
                    cmp_q     <= cmd_compare;
                    run_idx_q <= '0;
                end
                S_DRST:  rst_cnt_q <= (state_d == S_DRST) ? rst_cnt_q + 1'b1 : '0;
                S_START: counter_q <= CYCLE_W'(1);
                S_WAIT: begin
                    // Done wins over a coinciding timeout.
                    if (dut_done_port) begin
                        rec_cycles_q <= counter_q + 1'b1;
                        rec_status_q <= !cmp_q ? ST_NOCMP : (dut_success ? ST_PASS : ST_FAIL);
                    end else if (timed_out) begin
                        rec_cycles_q <= counter_q;
                        rec_status_q <= ST_TIMEOUT;
                    end else begin
                        counter_q <= counter_q + 1'b1;
                    end
                end
                S_RECORD: if (push_accept && !last_run) run_idx_q <= run_idx_q + 1'b1;
                default: ;
            endcase
        end
    end

    hls_result_fifo #(
        .WIDTH (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock       (clock),
        .reset       (reset),
        .push        (push),
        .push_data   (push_data),
        .push_accept (push_accept),
        .pop         (res_ready),
        .pop_data    (head),
        .empty       (fifo_empty)
    );

    assign res_valid   = !fifo_empty;
    assign res_status  = head[REC_W-1 -: STATUS_W];
    assign res_cycles  = head[RUN_W +: CYCLE_W];
    assign res_run_idx = head[RUN_W-1:0];

endmodule

// File: tb/tb_hls_run_controller.sv
// Scoreboard bench: batches queue expected results, a monitor checks every
// FIFO pop, and an accelerator model answers each start pulse.
module tb_hls_run_controller;

    localparam int CW = 32;
    localparam int RW = 8;
    localparam int TO = 50;
    localparam int RC = 2;
    localparam int FD = 2;

    typedef struct {
        logic [1:0]    st;
        logic [CW-1:0] cyc;
        logic [RW-1:0] idx;
    } res_t;

    logic          clock = 1'b0;
    logic          reset;
    logic          cmd_start, cmd_compare, dut_done_port, dut_success, res_ready;
    logic [RW-1:0] cmd_runs;
    logic          dut_reset, dut_start_port, res_valid, busy, batch_done;
    logic [1:0]    res_status;
    logic [CW-1:0] res_cycles;
    logic [RW-1:0] res_run_idx;

    int   checks = 0, errors = 0;
    int   starts = 0, batches = 0;
    int   lowcnt = 0, lastlow = 0;
    logic prev_rst = 1'b1;
    int   lat_q[$];
    bit   suc_q[$];
    res_t exp_q[$];

    always #5 clock = ~clock;

    hls_run_controller #(
        .CYCLE_W(CW), .RUN_W(RW), .TIMEOUT(TO), .RST_CYCLES(RC), .FIFO_DEPTH(FD)
    ) dut (
        .clock(clock), .reset(reset), .cmd_start(cmd_start), .cmd_runs(cmd_runs),
        .cmd_compare(cmd_compare), .dut_reset(dut_reset), .dut_start_port(dut_start_port),
        .dut_done_port(dut_done_port), .dut_success(dut_success), .res_valid(res_valid),
        .res_ready(res_ready), .res_status(res_status), .res_cycles(res_cycles),
        .res_run_idx(res_run_idx), .busy(busy), .batch_done(batch_done)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic run(input int lat, input bit suc);
        lat_q.push_back(lat);
        suc_q.push_back(suc);
    endtask

    task automatic expect_res(input logic [1:0] st, input int cyc, input int idx);
        res_t r;
        r.st = st; r.cyc = CW'(cyc); r.idx = RW'(idx);
        exp_q.push_back(r);
    endtask

    // done rises in the cycle that is lat cycles after the start cycle.
    task automatic drive_done(input int lat, input bit suc);
        repeat (lat) @(negedge clock);
        dut_done_port = 1'b1;
        dut_success   = suc;
        @(negedge clock);
        dut_done_port = 1'b0;
        dut_success   = 1'b0;
    endtask

    // Accelerator model plus check of the reset window preceding each start.
    initial begin
        forever begin
            @(negedge clock);
            if (!dut_reset) lowcnt++;
            else if (!prev_rst) begin lastlow = lowcnt; lowcnt = 0; end
            prev_rst = dut_reset;
            if (dut_start_port) begin
                starts++;
                chk("dut_reset_len", 64'(lastlow), 64'(RC));
                chk("start_expected", 64'(lat_q.size() > 0), 64'd1);
                if (lat_q.size() > 0) begin
                    automatic int l = lat_q.pop_front();
                    automatic bit s = suc_q.pop_front();
                    if (l > 0) fork drive_done(l, s); join_none
                end
            end
        end
    end

    // Scoreboard monitor: the head is checked whenever it will be popped.
    initial begin
        forever begin
            @(negedge clock);
            if (batch_done) batches++;
            if (reset && res_valid && res_ready) begin
                chk("pop_expected", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    automatic res_t e = exp_q.pop_front();
                    chk("res_status", 64'(res_status), 64'(e.st));
                    chk("res_cycles", 64'(res_cycles), 64'(e.cyc));
                    chk("res_run_idx", 64'(res_run_idx), 64'(e.idx));
                end
            end
        end
    end

    task automatic issue(input int runs, input bit cmp);
        @(negedge clock);
        cmd_start = 1'b1; cmd_runs = RW'(runs); cmd_compare = cmp;
        @(negedge clock);
        cmd_start = 1'b0;
    endtask

    task automatic wait_batch(input string name, input int maxc);
        int n = 0;
        while (!batch_done && n < maxc) begin @(negedge clock); n++; end
        chk(name, 64'(n < maxc), 64'd1);
        @(negedge clock);
    endtask

    task automatic drain(input string name, input int maxc);
        int n = 0;
        while (exp_q.size() != 0 && n < maxc) begin @(negedge clock); n++; end
        chk(name, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic set_ready(input logic v);
        @(posedge clock);
        #1 res_ready = v;
    endtask

    initial begin
        int s0, b0, n;
        bit seen;
        reset = 1'b0; cmd_start = 1'b0; cmd_runs = '0; cmd_compare = 1'b0;
        dut_done_port = 1'b0; dut_success = 1'b0; res_ready = 1'b1;
        repeat (3) @(negedge clock);
        chk("rst_dut_reset", 64'(dut_reset), 64'd0);
        chk("rst_dut_start", 64'(dut_start_port), 64'd0);
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_batch_done", 64'(batch_done), 64'd0);
        reset = 1'b1;
        @(negedge clock);
        chk("idle_dut_reset", 64'(dut_reset), 64'd1);

        // One run, compare off, done 10 cycles after start.
        s0 = starts; b0 = batches;
        run(10, 1'b0); expect_res(2'b00, 11, 0);
        issue(1, 1'b0);
        chk("busy_after_cmd", 64'(busy), 64'd1);
        wait_batch("t1_batch", 200);
        drain("t1_drain", 20);
        chk("t1_starts", 64'(starts - s0), 64'd1);
        chk("t1_batches", 64'(batches - b0), 64'd1);
        chk("t1_idle", 64'(busy), 64'd0);

        // Three runs with compare: pass, fail, pass.
        s0 = starts;
        run(4, 1'b1); run(7, 1'b0); run(3, 1'b1);
        expect_res(2'b01, 5, 0); expect_res(2'b10, 8, 1); expect_res(2'b01, 4, 2);
        issue(3, 1'b1);
        wait_batch("t2_batch", 300);
        drain("t2_drain", 20);
        chk("t2_starts", 64'(starts - s0), 64'd3);

        // Timeout on run 0, then a freshly reset run 1 completes.
        s0 = starts;
        run(0, 1'b0); run(5, 1'b1);
        expect_res(2'b11, TO, 0); expect_res(2'b01, 6, 1);
        issue(2, 1'b1);
        wait_batch("t3_batch", 400);
        drain("t3_drain", 20);
        chk("t3_starts", 64'(starts - s0), 64'd2);

        // Back-pressure: two results fill the FIFO, run 2 stalls in RECORD.
        s0 = starts; b0 = batches;
        set_ready(1'b0);
        for (int i = 0; i < 4; i++) begin run(3, 1'b0); expect_res(2'b00, 4, i); end
        issue(4, 1'b0);
        repeat (60) @(negedge clock);
        chk("t4_valid", 64'(res_valid), 64'd1);
        chk("t4_head_idx", 64'(res_run_idx), 64'd0);
        chk("t4_starts_stalled", 64'(starts - s0), 64'd3);
        chk("t4_busy", 64'(busy), 64'd1);
        repeat (10) @(negedge clock);
        chk("t4_head_stable", 64'(res_run_idx), 64'd0);
        chk("t4_head_cycles", 64'(res_cycles), 64'd4);
        chk("t4_still_stalled", 64'(starts - s0), 64'd3);
        chk("t4_no_batch_done", 64'(batches - b0), 64'd0);
        set_ready(1'b1);
        wait_batch("t4_batch", 200);
        drain("t4_drain", 20);
        chk("t4_starts", 64'(starts - s0), 64'd4);

        // Reset during WAIT of run 1: run 0 reported, run 1 dropped.
        s0 = starts; b0 = batches;
        run(4, 1'b0); run(0, 1'b0); run(0, 1'b0);
        expect_res(2'b00, 5, 0);
        issue(3, 1'b0);
        n = 0;
        while (starts - s0 < 2 && n < 100) begin @(negedge clock); n++; end
        chk("t5_run1_started", 64'(starts - s0), 64'd2);
        repeat (10) @(negedge clock);
        reset = 1'b0;
        #1;
        chk("t5_busy_in_reset", 64'(busy), 64'd0);
        chk("t5_fifo_empty", 64'(res_valid), 64'd0);
        chk("t5_dut_reset", 64'(dut_reset), 64'd0);
        @(negedge clock);
        reset = 1'b1;
        lat_q.delete(); suc_q.delete();
        repeat (80) @(negedge clock);
        chk("t5_no_result", 64'(res_valid), 64'd0);
        chk("t5_exp_empty", 64'(exp_q.size()), 64'd0);
        chk("t5_no_restart", 64'(starts - s0), 64'd2);
        chk("t5_no_batch_done", 64'(batches - b0), 64'd0);

        // Zero-run batch ends almost immediately with no DUT activity.
        s0 = starts;
        @(negedge clock);
        cmd_start = 1'b1; cmd_runs = '0; cmd_compare = 1'b1;
        seen = 1'b0; n = 0;
        while (!seen && n < 4) begin
            @(negedge clock);
            cmd_start = 1'b0;
            n++;
            seen = batch_done;
        end
        chk("t6_batch_done_seen", 64'(seen), 64'd1);
        chk("t6_latency_le2", 64'(n <= 2), 64'd1);
        repeat (5) @(negedge clock);
        chk("t6_no_start", 64'(starts - s0), 64'd0);
        chk("t6_no_result", 64'(res_valid), 64'd0);
        chk("t6_idle", 64'(busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/hls_run_controller.md
HLS_RUN_CONTROLLER -- requirements
Module: hls_run_controller

Interface
REQ-001 SHALL have parameter CYCLE_W, default 32, width of the cycle counter and result cycle field.
REQ-002 SHALL have parameter RUN_W, default 8, width of the run count and run index.
REQ-003 SHALL have parameter TIMEOUT, default 200000000, maximum cycles per run before abort.
REQ-004 SHALL have parameter RST_CYCLES, default 2, number of cycles the DUT reset is held before each run.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, result FIFO entries (power of two, at least 2).
REQ-006 SHALL have port clock, input, 1, the single clock; all logic is on its rising edge.
REQ-007 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port cmd_start, input, 1, one-cycle request to begin a batch.
REQ-009 SHALL have port cmd_runs, input, RUN_W, number of runs in the batch, sampled with cmd_start.
REQ-010 SHALL have port cmd_compare, input, 1, enables the pass/fail check, sampled with cmd_start.
REQ-011 SHALL have port dut_reset, output, 1, active-low reset to the accelerator.
REQ-012 SHALL have port dut_start_port, output, 1, one-cycle start pulse to the accelerator.
REQ-013 SHALL have port dut_done_port, input, 1, accelerator completion.
REQ-014 SHALL have port dut_success, input, 1, accelerator self-check result, valid when dut_done_port is high.
REQ-015 SHALL have port res_valid, output, 1, result FIFO non-empty.
REQ-016 SHALL have port res_ready, input, 1, consumer pops the head when both res_valid and res_ready are high.
REQ-017 SHALL have port res_status, output, 2, result status: 00 means no compare, 01 pass, 10 fail, 11 timeout.
REQ-018 SHALL have port res_cycles, output, CYCLE_W, measured cycle count for the run.
REQ-019 SHALL have port res_run_idx, output, RUN_W, index of the run, starting at 0.
REQ-020 SHALL have port busy, output, 1, high from acceptance of a batch until BATCH_END.
REQ-021 SHALL have port batch_done, output, 1, one-cycle pulse when the batch ends.

Function
REQ-022 SHALL implement the states IDLE, DRST, START, WAIT, RECORD and BATCH_END.
REQ-023 SHALL, in IDLE, accept cmd_start: go to DRST with the run index at 0, or go directly to BATCH_END if cmd_runs is 0; cmd_start is ignored outside IDLE.
REQ-024 SHALL, in DRST, drive dut_reset low for exactly RST_CYCLES cycles, then go to START.
REQ-025 SHALL, in START, drive dut_start_port high for exactly one cycle, load the counter with 1, then go to WAIT.
REQ-026 SHALL, in WAIT, increment the counter once per cycle and never let it wrap (saturate at TIMEOUT).
REQ-027 SHALL, on the first WAIT cycle with dut_done_port high, capture the counter value plus one; status is 00 if compare is off, otherwise 01 if dut_success is high and 10 if not.
REQ-028 SHALL, when the counter equals TIMEOUT and dut_done_port is low, capture cycles equal to TIMEOUT with status 11; if done and timeout coincide, done takes priority.
REQ-029 SHALL, in RECORD, push {status, cycles, run index} into the FIFO; if the FIFO is full, stay in RECORD until space is available.
REQ-030 SHALL, after the push, go to BATCH_END if the run index equals cmd_runs minus 1; otherwise increment the run index and go to DRST, so that every run, including one after a timeout, starts from a freshly reset DUT.
REQ-031 SHALL, in BATCH_END, pulse batch_done for one cycle and return to IDLE; the FIFO is not cleared.
REQ-032 SHALL allow a push and a pop in the same cycle when the FIFO is full, and the push SHALL succeed.
REQ-033 SHALL keep the FIFO head stable while res_valid is high and res_ready is low.
REQ-034 SHALL ignore dut_done_port outside WAIT.

Reset
REQ-035 SHALL, on reset low, immediately enter IDLE and empty the FIFO.
REQ-036 SHALL, while reset is low, drive dut_reset 0, dut_start_port 0, res_valid 0, busy 0, batch_done 0, and clear the counter and run index.
REQ-037 SHALL, if reset is asserted mid-run, abandon the run without producing a result.

Structure
REQ-038 SHALL place the status encodings, the state enumeration and the result record width in a shared package, hls_run_pkg.
REQ-039 SHALL implement the FIFO as the sub-module hls_result_fifo, parametrised by width and depth.

Verification
REQ-040 SHALL cover: cmd_runs=1, compare off, done 10 cycles after start -> one result {00, 11, 0}, then batch_done.
REQ-041 SHALL cover: cmd_runs=3, compare on, dut_success 1,0,1 -> statuses 01,10,01 with run indices 0,1,2.
REQ-042 SHALL cover: TIMEOUT=50 with done never asserted -> {11, 50, 0}, followed by a fresh reset and start for the next run.
REQ-043 SHALL cover: FIFO_DEPTH=2, cmd_runs=4, res_ready held low -> stall in RECORD after 2 results; releasing res_ready drains all 4 results in order.
REQ-044 SHALL cover: reset pulsed low during WAIT of run 1 -> busy 0, FIFO empty, no result for run 1.
REQ-045 SHALL cover: cmd_runs=0 -> batch_done 2 cycles after cmd_start, no DUT start and no results.
